// File: rtl/score_bcd_counter.sv
// Snake-game BCD score keeper with saturation, speed-up flag and high-score latch.
// Define SCORE_HIGH_SCORE_EN to build the high-score register and COMMIT compare.
module score_bcd_counter #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned POINTS      = 1,
  parameter logic [31:0] FAST_THRESH = 32'h0000_0010
) (
  input  logic                  clkin,
  input  logic                  resetn,
  input  logic                  eat,
  input  logic                  game_over,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   score,
  output logic [4*DIGITS-1:0]   high_score,
  output logic                  speed_fast,
  output logic                  saturated,
  output logic                  new_high
);

  localparam int unsigned W = 4 * DIGITS;
  localparam logic [W-1:0] Nines = {DIGITS{4'h9}};

  typedef enum logic [1:0] {StRun, StCommit, StFrozen} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   score_q, score_d;
  logic           speed_q, speed_d;
  logic           sat_q, sat_d;
  logic           eat_q, go_q;
  logic           eat_rise, go_rise;
  logic [W-1:0]   inc_score;
  logic           inc_ovf;
  logic [4:0]     dsum;
  logic           carry;

  assign eat_rise = eat & ~eat_q;
  assign go_rise  = game_over & ~go_q;

  // Decimal ripple add of POINTS into the least significant digit.
  always_comb begin
    carry     = 1'b0;
    dsum      = '0;
    inc_score = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      dsum = {1'b0, score_q[4*i +: 4]} + {4'b0, carry} + ((i == 0) ? 5'(POINTS) : 5'd0);
      if (dsum > 5'd9) begin
        dsum  = dsum - 5'd10;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      inc_score[4*i +: 4] = dsum[3:0];
    end
    inc_ovf = carry;
  end

  always_comb begin
    score_d = score_q;
    state_d = state_q;
    if (clear) begin
      score_d = '0;
      state_d = StRun;
    end else begin
      unique case (state_q)
        StRun: begin
          if (eat_rise) score_d = inc_ovf ? Nines : inc_score;
          if (go_rise)  state_d = StCommit;
        end
        StCommit: state_d = StFrozen;
        StFrozen: state_d = StFrozen;
        default:  state_d = StRun;
      endcase
    end
    speed_d = 32'(score_d) >= FAST_THRESH;
    sat_d   = (score_d == Nines);
  end

  always_ff @(posedge clkin) begin
    if (!resetn) begin
      state_q <= StRun;
      score_q <= '0;
      speed_q <= 1'b0;
      sat_q   <= 1'b0;
      eat_q   <= 1'b0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      speed_q <= speed_d;
      sat_q   <= sat_d;
      eat_q   <= eat;
      go_q    <= game_over;
    end
  end

  assign score      = score_q;
  assign speed_fast = speed_q;
  assign saturated  = sat_q;

`ifdef SCORE_HIGH_SCORE_EN
  logic [W-1:0] high_q, high_d;
  logic         new_high_q, new_high_d;

  // A clear during COMMIT aborts the update.
  always_comb begin
    high_d     = high_q;
    new_high_d = 1'b0;
    if (state_q == StCommit && !clear && score_q > high_q) begin
      high_d     = score_q;
      new_high_d = 1'b1;
    end
  end

  always_ff @(posedge clkin) begin
    if (!resetn) begin
      high_q     <= '0;
      new_high_q <= 1'b0;
    end else begin
      high_q     <= high_d;
      new_high_q <= new_high_d;
    end
  end

  assign high_score = high_q;
  assign new_high   = new_high_q;
`else
  assign high_score = '0;
  assign new_high   = 1'b0;
`endif

endmodule
